// File: rtl/filter_gpu_pkg.sv
// -----------------------------------------------------------------------------
// filter_gpu_pkg
//
// Shared types and sizes for the filter GPU memory path. The vector types are
// also used by the GPU datapath's 3-lane memory ports, so the vector
// sequencer and the datapath agree on lane ordering: lane 0 is element [0],
// which is the least-significant slice of a packed vector.
// -----------------------------------------------------------------------------
package filter_gpu_pkg;

    // Vector lanes per access, RAM address width, pixel/data word width.
    localparam int LANES = 3;
    localparam int AW    = 10;
    localparam int DW    = 18;

    typedef logic [DW-1:0]        pixel_t;
    typedef logic [AW-1:0]        paddr_t;
    typedef pixel_t [LANES-1:0]   vec_pixel_t;
    typedef paddr_t [LANES-1:0]   vec_addr_t;

    // Vector memory sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } vms_state_t;

endpackage : filter_gpu_pkg

// File: rtl/vec_mem_sequencer.sv
// -----------------------------------------------------------------------------
// vec_mem_sequencer
//
// Serialises one 3-lane vector access from the filter GPU memory stage into
// three single-word accesses on a single-port pixel RAM, in lane order 0,1,2,
// and gathers the read data back into one 3-lane response word.
//
// Ports
//   CLK        single clock, all state on the rising edge
//   RST        asynchronous, active-high reset
//   req_valid  vector request present
//   req_ready  high in IDLE; request accepted when high with req_valid
//   req_we     1 = vector write, 0 = vector read
//   req_addr   per-lane RAM address
//   req_wdata  per-lane write data
//   busy       high whenever not in IDLE (pipeline stall)
//   rsp_valid  one-cycle completion pulse for reads and writes
//   rsp_rdata  gathered read data, held until the next read completes
//   mem_en     RAM access strobe
//   mem_we     RAM write strobe (qualified by mem_en)
//   mem_addr   RAM address
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data, valid the cycle after the read strobe
//
// Timing, with acceptance at the edge ending cycle 0:
//   cycles 1..3 issue lanes 0..2, cycle 4 drains the last read word,
//   cycle 5 pulses rsp_valid, cycle 6 is IDLE again.
// Every output is a register, so nothing on req_* reaches mem_* or
// req_ready combinationally.
// -----------------------------------------------------------------------------
module vec_mem_sequencer #(
    parameter int LANES = filter_gpu_pkg::LANES,
    parameter int AW    = filter_gpu_pkg::AW,
    parameter int DW    = filter_gpu_pkg::DW
) (
    input  logic                        CLK,
    input  logic                        RST,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [LANES-1:0][AW-1:0]    req_addr,
    input  logic [LANES-1:0][DW-1:0]    req_wdata,

    output logic                        busy,
    output logic                        rsp_valid,
    output logic [LANES-1:0][DW-1:0]    rsp_rdata,

    output logic                        mem_en,
    output logic                        mem_we,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_wdata,
    input  logic [DW-1:0]               mem_rdata
);

    import filter_gpu_pkg::*;

    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    vms_state_t                     state;
    logic [1:0]                     lane;

    // Request captured at acceptance; later req_* activity is ignored.
    logic                           we_q;
    logic [LANES-1:0][AW-1:0]       addr_q;
    logic [LANES-1:0][DW-1:0]       wdata_q;

    // Read words for lanes 0..LANES-2. Data returns strictly in lane order,
    // so a shift register replaces the indexed write rdata[lane-1]; after the
    // last ISSUE cycle element [i] holds lane i. The final lane's word is
    // taken straight from mem_rdata in DRAIN.
    logic [LANES-2:0][DW-1:0]       rdata_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            lane      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= ISSUE;
                        lane      <= '0;
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        // Lane 0 is presented in the first ISSUE cycle, so
                        // its strobe and operands are loaded at acceptance.
                        mem_en    <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= req_addr[0];
                        mem_wdata <= req_wdata[0];
                    end
                end

                ISSUE: begin
                    // Word for the lane issued last cycle is on mem_rdata now.
                    if (!we_q && lane != 2'd0) begin
                        rdata_q <= {mem_rdata, rdata_q[LANES-2:1]};
                    end

                    if (lane == LAST_LANE) begin
                        state     <= DRAIN;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end else begin
                        lane      <= lane + 2'd1;
                        mem_addr  <= addr_q[lane + 2'd1];
                        mem_wdata <= wdata_q[lane + 2'd1];
                    end
                end

                DRAIN: begin
                    // Last lane's word arrives here; publish the whole vector
                    // so rsp_rdata is already stable when rsp_valid rises.
                    if (!we_q) begin
                        rsp_rdata <= {mem_rdata, rdata_q};
                    end
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    state     <= IDLE;
                    lane      <= '0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    lane      <= '0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

endmodule : vec_mem_sequencer

// File: tb/tb_vec_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vec_mem_sequencer
//
// Bench for vec_mem_sequencer: a synchronous pixel RAM model on the mem_*
// side, a lane-ordered shadow memory as the reference for vector results,
// a table of directed vectors, a continuous req_valid phase, a reset-abort
// sequence and randomized vector accesses.
// -----------------------------------------------------------------------------
module tb_vec_mem_sequencer;
    import filter_gpu_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    vec_addr_t  req_addr = '0;
    vec_pixel_t req_wdata = '0;
    logic       busy;
    logic       rsp_valid;
    vec_pixel_t rsp_rdata;
    logic       mem_en;
    logic       mem_we;
    paddr_t     mem_addr;
    pixel_t     mem_wdata;
    pixel_t     mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    vec_mem_sequencer #(
        .LANES (LANES),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-port RAM: one-cycle read latency, plus a bench load port.
    pixel_t ram [0:1023];
    logic   ld_en = 1'b0;
    paddr_t ld_addr = '0;
    pixel_t ld_data = '0;

    always @(posedge CLK) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata    <= ram[mem_addr];
        end
    end

    // Reference: a vector write stores lanes in order (last lane wins on
    // duplicates); a vector read returns the stored words; a write leaves the
    // previous response unchanged.
    pixel_t     shadow [0:1023];
    vec_pixel_t last_rsp = '0;

    function automatic vec_pixel_t model(input logic we, input vec_addr_t a,
                                         input vec_pixel_t d);
        vec_pixel_t r;
        if (we) begin
            for (int i = 0; i < LANES; i++) shadow[a[i]] = d[i];
        end else begin
            for (int i = 0; i < LANES; i++) r[i] = shadow[a[i]];
            last_rsp = r;
        end
        return last_rsp;
    endfunction

    typedef struct {
        logic       we;
        vec_addr_t  addr;
        vec_pixel_t wdata;
        vec_pixel_t exp;
    } vec_t;

    function automatic vec_addr_t mka(input int a0, input int a1, input int a2);
        vec_addr_t r;
        r[0] = paddr_t'(a0);
        r[1] = paddr_t'(a1);
        r[2] = paddr_t'(a2);
        return r;
    endfunction

    function automatic vec_pixel_t mkd(input int d0, input int d1, input int d2);
        vec_pixel_t r;
        r[0] = pixel_t'(d0);
        r[1] = pixel_t'(d1);
        r[2] = pixel_t'(d2);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input paddr_t a, input pixel_t d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        shadow[a] = d;
        tick();
        ld_en = 1'b0;
    endtask

    // One vector access from IDLE, checked every cycle from acceptance to
    // the IDLE cycle that follows the response.
    task automatic do_access(input string tag, input logic we, input vec_addr_t a,
                             input vec_pixel_t d, input vec_pixel_t exp);
        int w;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        chk({tag, " accept_wait"}, 64'(w), 64'd0);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        tick();
        // Scramble the request after acceptance; the sequencer must not care.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = mka($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
        req_wdata = mkd($urandom, $urandom, $urandom);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("%s c%0d busy", tag, c), 64'(busy), 64'(c <= 5));
            chk($sformatf("%s c%0d req_ready", tag, c), 64'(req_ready), 64'(c > 5));
            chk($sformatf("%s c%0d rsp_valid", tag, c), 64'(rsp_valid), 64'(c == 5));
            if (c <= 3) begin
                chk($sformatf("%s c%0d mem_en", tag, c), 64'(mem_en), 64'd1);
                chk($sformatf("%s c%0d mem_we", tag, c), 64'(mem_we), 64'(we));
                chk($sformatf("%s c%0d mem_addr", tag, c), 64'(mem_addr), 64'(a[c-1]));
                chk($sformatf("%s c%0d mem_wdata", tag, c), 64'(mem_wdata), 64'(d[c-1]));
            end else begin
                chk($sformatf("%s c%0d mem_idle", tag, c),
                    {mem_en, mem_we, 8'd0, mem_addr, 8'd0, mem_wdata}, 64'd0);
            end
            if (c >= 5) begin
                chk($sformatf("%s c%0d rsp_rdata", tag, c), 64'(rsp_rdata), 64'(exp));
            end
            if (c < 6) tick();
        end
    endtask

    vec_t tbl [6];

    initial begin
        vec_t cur;
        int   acc_n;
        int   n_acc;
        int   k;
        logic rwe;
        vec_addr_t  ra;
        vec_pixel_t rd;

        // Memory contents, loaded while the sequencer is held in reset.
        for (int a = 0; a < 32; a++) preload(paddr_t'(a), pixel_t'((a * 311) ^ 18'h2A5A5));
        preload(10'd5,    18'h00011);
        preload(10'd6,    18'h00022);
        preload(10'd7,    18'h3FFFF);
        preload(10'd0,    18'h12345);
        preload(10'd1023, 18'h2AAAA);
        preload(10'd512,  18'h15555);

        tbl[0] = '{1'b0, mka(5, 6, 7),        '0,              mkd('h00011, 'h00022, 'h3FFFF)};
        tbl[1] = '{1'b1, mka(10, 11, 12),     mkd(1, 2, 3),    mkd('h00011, 'h00022, 'h3FFFF)};
        tbl[2] = '{1'b0, mka(10, 11, 12),     '0,              mkd(1, 2, 3)};
        tbl[3] = '{1'b1, mka(20, 20, 20),     mkd('hA, 'hB, 'hC), mkd(1, 2, 3)};
        tbl[4] = '{1'b0, mka(20, 20, 20),     '0,              mkd('hC, 'hC, 'hC)};
        tbl[5] = '{1'b0, mka(0, 1023, 512),   '0,              mkd('h12345, 'h2AAAA, 'h15555)};

        // Reset values.
        chk("rst req_ready", 64'(req_ready), 64'd1);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst mem", {mem_en, mem_we, 8'd0, mem_addr, 8'd0, mem_wdata}, 64'd0);
        RST = 1'b0;

        // Directed table; the first entry is accepted on the first edge
        // after reset release.
        for (int i = 0; i < 6; i++) begin
            void'(model(tbl[i].we, tbl[i].addr, tbl[i].wdata));
            do_access($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
        end

        // req_valid held high with new inputs every cycle.
        acc_n = -100;
        n_acc = 0;
        cur   = '{1'b0, '0, '0, '0};
        req_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            k = n - acc_n;
            chk($sformatf("cont n%0d ready_vs_busy", n), 64'(req_ready), 64'(!busy));
            chk($sformatf("cont n%0d rsp_valid", n), 64'(rsp_valid), 64'(k == 5));
            if (k >= 1 && k <= 3) begin
                chk($sformatf("cont n%0d mem_en", n), 64'(mem_en), 64'd1);
                chk($sformatf("cont n%0d mem_we", n), 64'(mem_we), 64'(cur.we));
                chk($sformatf("cont n%0d mem_addr", n), 64'(mem_addr), 64'(cur.addr[k-1]));
                chk($sformatf("cont n%0d mem_wdata", n), 64'(mem_wdata), 64'(cur.wdata[k-1]));
            end
            if (k == 5) chk($sformatf("cont n%0d rsp_rdata", n), 64'(rsp_rdata), 64'(cur.exp));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = mka($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            req_wdata = mkd($urandom, $urandom, $urandom);
            if (req_ready) begin
                if (acc_n >= 0) chk($sformatf("cont n%0d spacing", n), 64'(n - acc_n), 64'd6);
                cur.we    = req_we;
                cur.addr  = req_addr;
                cur.wdata = req_wdata;
                cur.exp   = model(req_we, req_addr, req_wdata);
                acc_n     = n;
                n_acc++;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("cont acceptances", 64'(n_acc), 64'd10);
        for (int n = 0; n < 3; n++) tick();

        // Reset in cycle 2 of a read.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = mka(3, 4, 5);
        k = 0;
        while (!req_ready && k < 20) begin
            tick();
            k++;
        end
        chk("abort accept_wait", 64'(k), 64'd0);
        tick();
        req_valid = 1'b0;
        tick();
        chk("abort c2 mem_en", 64'(mem_en), 64'd1);
        #2 RST = 1'b1;
        #1;
        chk("abort mem", {mem_en, mem_we, 8'd0, mem_addr, 8'd0, mem_wdata}, 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort req_ready", 64'(req_ready), 64'd1);
        chk("abort rsp_rdata", 64'(rsp_rdata), 64'd0);
        last_rsp = '0;
        tick();
        RST = 1'b0;
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("abort n%0d rsp_valid", n), 64'(rsp_valid), 64'd0);
            chk($sformatf("abort n%0d rsp_rdata", n), 64'(rsp_rdata), 64'd0);
            tick();
        end
        ra = mka(5, 6, 7);
        do_access("post_rst", 1'b0, ra, '0, model(1'b0, ra, '0));

        // Randomized accesses over a small address window to force overlap.
        for (int i = 0; i < 40; i++) begin
            vec_pixel_t e;
            rwe = 1'($urandom_range(0, 1));
            ra  = mka($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            rd  = mkd($urandom, $urandom, $urandom);
            e   = model(rwe, ra, rd);
            do_access($sformatf("rnd%0d", i), rwe, ra, rd, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_vec_mem_sequencer

// File: doc/vec_mem_sequencer.md
# vec_mem_sequencer

Sits between the filter GPU's memory stage and the single-port 18-bit pixel RAM. Accepts one 3-lane vector access (three 10-bit addresses, three 18-bit data words, one write-enable) and serialises it into three single-word RAM accesses in lane order 0, 1, 2. It returns the gathered read data as one 3-lane word. It also drives a busy/stall indication back to the pipeline.

## Interface
Parameters:
- LANES, 3, vector lanes per access
- AW, 10, RAM address width
- DW, 18, pixel/data word width

Ports:
- CLK  in  1  single clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- req_valid  in  1  vector request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_we  in  1  1 = vector write, 0 = vector read
- req_addr  in  LANES×AW  per-lane address
- req_wdata  in  LANES×DW  per-lane write data
- busy  out  1  high whenever the sequencer is not in IDLE; pipeline stalls on it
- rsp_valid  out  1  one-cycle completion pulse, for reads and writes
- rsp_rdata  out  LANES×DW  gathered read data, held until the next read completes
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write strobe, only meaningful with mem_en
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after the mem_en read cycle

## Operation
- FSM states are IDLE, ISSUE, DRAIN and DONE, with a 2-bit lane counter `lane`.
- IDLE: req_ready=1, busy=0. On req_valid, capture req_we, req_addr and req_wdata into registers, set lane=0 and go to ISSUE.
- ISSUE: mem_en=1, mem_we=captured we, mem_addr=addr[lane], mem_wdata=wdata[lane].
  - On a read, when lane≥1, capture mem_rdata into rdata[lane-1].
  - Increment lane; after lane 2, go to DRAIN.
- DRAIN: mem_en=0. On a read, capture mem_rdata into rdata[2]. Go to DONE.
- DONE: rsp_valid=1 and busy=1. Go to IDLE.
- Request inputs are sampled only at acceptance. Later changes on them are ignored. req_valid outside IDLE is ignored, not queued.
- Write data and addresses pass through unchanged, with no arithmetic.
- Duplicate lane addresses on a write: the accesses occur in lane order, so lane 2's data persists.
- Duplicate addresses on a read: every lane returns the same word.
- A write completion leaves rsp_rdata unchanged.
- In any state other than ISSUE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: FSM=IDLE, lane=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, and all mem_* outputs 0. All captured registers clear to 0.
- Take acceptance at the edge ending cycle 0.
  - Cycles 1, 2 and 3 issue lanes 0, 1 and 2.
  - Cycle 4 is DRAIN.
  - Cycle 5 is DONE with rsp_valid=1.
  - Cycle 6 is IDLE and can accept the next request.
- Fixed latency is 5 cycles from acceptance to rsp_valid. Maximum throughput is one vector per 6 cycles.
- For reads, rsp_rdata is valid and stable from cycle 5 onward.
- busy is high in cycles 1–5. req_ready is the exact complement of busy.
- All outputs are driven from registers or the FSM state. There is no combinational path from req_* to mem_* or to req_ready.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronously).
  - The in-flight access is abandoned and no rsp_valid is issued.
  - RAM writes already issued are not undone.
- Reset deasserted: the first acceptance can occur on the first rising edge with RST low.

## Structure
- Shared package `filter_gpu_pkg` holds:
  - the LANES, AW and DW localparams
  - `typedef logic [DW-1:0] pixel_t`
  - `typedef logic [AW-1:0] paddr_t`
  - `typedef pixel_t [LANES-1:0] vec_pixel_t`
  - `typedef paddr_t [LANES-1:0] vec_addr_t`
  - the enum `vms_state_t` {IDLE, ISSUE, DRAIN, DONE}
- These types are shared with the GPU datapath's 3-lane memory ports.
- Single module, no sub-module. The FSM, lane counter and capture registers are small enough to live together.

## Test plan
- Reset release, then a read request with addr={5,6,7}, RAM preloaded {0x00011,0x00022,0x3FFFF}.
  - mem_addr is 5, 6, 7 in cycles 1–3 with mem_we=0.
  - rsp_valid pulses in cycle 5 with rsp_rdata={0x00011,0x00022,0x3FFFF}.
- Write of {0x1,0x2,0x3} to {10,11,12}, then a read of the same addresses.
  - mem_we=1 in cycles 1–3.
  - The read returns {0x1,0x2,0x3}.
  - rsp_rdata does not change at the write's DONE.
- Write with duplicate addresses {20,20,20} and data {A,B,C}, then a read of 20.
  - All lanes return C.
- req_valid held high continuously with changing inputs.
  - Acceptances occur every 6 cycles.
  - Inputs changed after acceptance have no effect.
  - busy and req_ready are complementary every cycle.
- RST asserted in cycle 2 of a read.
  - mem_en drops immediately.
  - There is no rsp_valid pulse.
  - rsp_rdata=0.
  - The next request after reset completes normally with 5-cycle latency.
- Read with boundary addresses {0,1023,512}.
  - mem_addr wraps nothing and presents exactly those values.
  - Data is returned in lane order.
